apogee_mem_arbiter: RTL
=======================

# apogee_mem_arbiter

Single-port arbiter sharing the system SDRAM between three requesters: the ROM/file loader, the video DMA channel (CRT character fetch) and the CPU. Sits between the requesters and the SDRAM controller, serialises accesses with a req/ack handshake and drives the CPU wait line. Fixed priority: loader > DMA > CPU, with an optional CPU anti-starvation rule and a watchdog that aborts stalled transactions.

## Interface
Parameters:
- AW, 25, memory address width
- DW, 8, data width
- TIMEOUT, 64, cycles in BUSY before abort (≥2)
- MAX_DMA_RUN, 4, consecutive DMA grants tolerated while CPU pending (only with anti-starvation)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ld_req / ld_addr / ld_din  in  1/AW/DW  loader write request, level, held until ld_ack
- ld_ack  out  1  one-cycle completion pulse
- dma_req / dma_addr  in  1/AW  DMA read request, held until dma_ack
- dma_ack  out  1  one-cycle pulse; rdata valid same cycle
- cpu_req / cpu_we / cpu_addr / cpu_din  in  1/1/AW/DW  CPU request, held until cpu_ack
- cpu_ack  out  1  one-cycle pulse; rdata valid same cycle on reads
- cpu_wait  out  1  cpu_req & ~cpu_ack (combinational; drives CPU ready low)
- rdata  out  DW  read data, holds last value
- mem_req / mem_we / mem_addr / mem_din  out  1/1/AW/DW  registered SDRAM command
- mem_ack / mem_dout  in  1/DW  SDRAM completion, read data valid with mem_ack
- timeout  out  1  one-cycle pulse on watchdog abort

## Operation
- FSM: IDLE, BUSY, RESP.
- IDLE: sample requests; pick winner (ld > dma > cpu); latch grant, addr, we, din into mem_* regs; mem_req<=1; go BUSY. No request: stay.
- Loader always write (mem_we=1); DMA always read; CPU per cpu_we.
- BUSY: hold mem_* stable. mem_ack=1 → mem_req<=0, rdata<=mem_dout if read, go RESP. Watchdog counter reaches TIMEOUT-1 without ack → mem_req<=0, rdata<=8'hFF if read, timeout pulse, go RESP.
- RESP: pulse ack of granted requester; go IDLE. Requester must drop req in the ack cycle; a req still high in IDLE is a new transaction.
- mem_ack outside BUSY ignored (covers late ack after abort or reset).
- No preemption: higher-priority request arriving in BUSY waits for RESP→IDLE.
- Writes do not update rdata.

## Timing
- Reset values: mem_req/mem_we/all acks/timeout 0; mem_addr, mem_din, rdata 0; state IDLE; counters 0.
- Request visible at edge N in IDLE → mem_req high from N+1.
- mem_ack sampled at edge M → mem_req low and rdata valid from M+1, X_ack high in cycle M+1 only.
- Minimum cycle per transaction: 3 clocks with zero-wait memory (ack in first BUSY cycle).
- Watchdog: counts BUSY cycles from 0; abort on edge with count==TIMEOUT-1; counter cleared in IDLE.
- reset_n low at any point: immediate return to reset values; in-flight access abandoned, no ack issued.
- Simultaneous requests: only winner proceeds; losers keep req high and win subsequent IDLE slots by priority.

## Configuration
- APOGEE_ARB_ANTISTARVE_EN defined: counter of consecutive DMA grants taken while cpu_req high; when count==MAX_DMA_RUN, next IDLE arbitration ranks CPU above DMA (loader still highest); counter clears on CPU grant or when cpu_req low at grant time.
- Undefined: strict loader > DMA > CPU; counter logic absent.

## Structure
- Package apogee_arb_pkg: state enum (ST_IDLE, ST_BUSY, ST_RESP), grant enum (GNT_NONE, GNT_LD, GNT_DMA, GNT_CPU), default AW/DW constants.
- One sub-module: apogee_arb_pick — combinational priority picker taking three requests plus cpu_boost, returning grant enum.

## Test plan
- Single CPU read 0x0_1234, mem_ack after 2 BUSY cycles with 0x5A → cpu_ack one cycle, rdata=0x5A, cpu_wait low in ack cycle, 4 clocks req-to-ack.
- ld, dma, cpu all raised same cycle, zero-wait memory → grants ld, dma, cpu in order, acks 3 cycles apart.
- CPU read with mem_ack never asserted, TIMEOUT=64 → timeout and cpu_ack pulse 64 cycles after mem_req rise, rdata=0xFF.
- reset_n low in BUSY, then mem_ack arrives after release → no ack pulses, mem_req 0, FSM stays IDLE.
- DMA held continuously, CPU pending, MAX_DMA_RUN=4: with APOGEE_ARB_ANTISTARVE_EN CPU granted after 4 DMA grants; without, CPU never granted until dma_req drops.
- CPU write 0xA5 to 0x1_0000 then read → mem_we=1 with mem_din=0xA5, rdata unchanged by write, read returns model value.

Source files
------------

// File: rtl/apogee_arb_pkg.sv
// Shared types for the SDRAM arbiter: FSM states, grant codes,
// and default bus widths.
package apogee_arb_pkg;

    localparam int ARB_AW = 25;
    localparam int ARB_DW = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_LD,
        GNT_DMA,
        GNT_CPU
    } grant_e;

endpackage

// File: rtl/apogee_arb_pick.sv
// Combinational priority picker: loader > DMA > CPU, except that a
// boosted CPU request outranks DMA (the loader always stays on top).
module apogee_arb_pick
    import apogee_arb_pkg::*;
(
    input  logic   ld_req,
    input  logic   dma_req,
    input  logic   cpu_req,
    input  logic   cpu_boost,
    output grant_e gnt
);

    always_comb begin
        gnt = GNT_NONE;
        if (ld_req)
            gnt = GNT_LD;
        else if (cpu_boost && cpu_req)
            gnt = GNT_CPU;
        else if (dma_req)
            gnt = GNT_DMA;
        else if (cpu_req)
            gnt = GNT_CPU;
    end

endmodule

// File: rtl/apogee_mem_arbiter.sv
// Loader/DMA/CPU arbiter in front of the SDRAM controller, with a watchdog.
// Define APOGEE_ARB_ANTISTARVE_EN to cap consecutive DMA wins over a waiting CPU.
module apogee_mem_arbiter
    import apogee_arb_pkg::*;
#(
    parameter int AW          = ARB_AW,
    parameter int DW          = ARB_DW,
    parameter int TIMEOUT     = 64,
    parameter int MAX_DMA_RUN = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_din,
    output logic          ld_ack,
    input  logic          dma_req,
    input  logic [AW-1:0] dma_addr,
    output logic          dma_ack,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic          cpu_ack,
    output logic          cpu_wait,
    output logic [DW-1:0] rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_dout,
    output logic          timeout
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

    if (TIMEOUT < 2 || MAX_DMA_RUN < 1) begin : g_cfg_err
        $error("apogee_mem_arbiter: need TIMEOUT >= 2, MAX_DMA_RUN >= 1");
    end

    state_e        state;
    grant_e        gnt;
    grant_e        pick;
    logic [TW-1:0] wd_cnt;
    logic          cpu_boost;
    logic          done;

    apogee_arb_pick u_pick (
        .ld_req    (ld_req),
        .dma_req   (dma_req),
        .cpu_req   (cpu_req),
        .cpu_boost (cpu_boost),
        .gnt       (pick)
    );

`ifdef APOGEE_ARB_ANTISTARVE_EN
    localparam int RW = $clog2(MAX_DMA_RUN + 1);

    logic [RW-1:0] dma_run;

    // Only DMA wins taken while the CPU was already waiting count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dma_run <= '0;
        end else if (state == ST_IDLE && pick != GNT_NONE) begin
            if (pick == GNT_CPU || !cpu_req)
                dma_run <= '0;
            else if (pick == GNT_DMA)
                dma_run <= dma_run + 1'b1;
        end
    end

    assign cpu_boost = (dma_run == RW'(MAX_DMA_RUN));
`else
    assign cpu_boost = 1'b0;
`endif

    assign done     = mem_ack || (wd_cnt == WD_LAST);
    assign cpu_wait = cpu_req & ~cpu_ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            gnt      <= GNT_NONE;
            wd_cnt   <= '0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            rdata    <= '0;
            ld_ack   <= 1'b0;
            dma_ack  <= 1'b0;
            cpu_ack  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            ld_ack  <= 1'b0;
            dma_ack <= 1'b0;
            cpu_ack <= 1'b0;
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    wd_cnt <= '0;
                    if (pick != GNT_NONE) begin
                        gnt     <= pick;
                        mem_req <= 1'b1;
                        state   <= ST_BUSY;
                    end
                    case (pick)
                        GNT_LD: begin
                            mem_we   <= 1'b1;
                            mem_addr <= ld_addr;
                            mem_din  <= ld_din;
                        end
                        GNT_DMA: begin
                            mem_we   <= 1'b0;
                            mem_addr <= dma_addr;
                        end
                        GNT_CPU: begin
                            mem_we   <= cpu_we;
                            mem_addr <= cpu_addr;
                            mem_din  <= cpu_din;
                        end
                        default: ;
                    endcase
                end
                ST_BUSY: begin
                    // A real ack wins over an abort landing on the same edge.
                    if (done) begin
                        mem_req <= 1'b0;
                        state   <= ST_RESP;
                        ld_ack  <= (gnt == GNT_LD);
                        dma_ack <= (gnt == GNT_DMA);
                        cpu_ack <= (gnt == GNT_CPU);
                        timeout <= ~mem_ack;
                        if (!mem_we)
                            rdata <= mem_ack ? mem_dout : '1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
